// File: rtl/skid_pkg.sv
// -----------------------------------------------------------------------------
// skid_pkg
//   Shared definitions for the elastic skid buffer.
//   - state_e : control state of the two-entry slice. The encoding is chosen so
//               that the state value equals the number of held entries, which
//               lets occupancy be read straight from the state register.
//   - OCC_W   : width of the occupancy output.
// -----------------------------------------------------------------------------
package skid_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        BUSY  = 2'd1,   // main register valid
        FULL  = 2'd2    // main and skid registers valid
    } state_e;

endpackage : skid_pkg

// File: rtl/data_reg_en.sv
// -----------------------------------------------------------------------------
// data_reg_en
//   Width-parameterised data register with load enable and asynchronous
//   active-low reset to zero. The register only toggles when en_i is high.
//
//   Ports:
//     clk_i     in   clock, rising edge
//     reset_ni  in   asynchronous active-low reset (clears q_o)
//     en_i      in   load enable
//     d_i       in   Width  data to load
//     q_o       out  Width  registered data
// -----------------------------------------------------------------------------
module data_reg_en #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule : data_reg_en

// File: rtl/elastic_skid_buffer.sv
// -----------------------------------------------------------------------------
// elastic_skid_buffer
//   Two-entry valid/ready register slice. Breaks both the forward valid/data
//   path and the backward ready path between producer and consumer while
//   sustaining one transfer per cycle.
//
//   Ports:
//     clk_i        in   clock, rising edge
//     reset_ni     in   asynchronous active-low reset
//     valid_i      in   upstream has data on data_i
//     ready_o      out  slice can accept (registered)
//     data_i       in   Width  upstream payload
//     valid_o      out  slice presents data on data_o
//     ready_i      in   downstream accepts
//     data_o       out  Width  downstream payload (main register)
//     occupancy_o  out  2      held entries: 0, 1 or 2
// -----------------------------------------------------------------------------
module elastic_skid_buffer
    import skid_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic [OCC_W-1:0] occupancy_o
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_ready;
    logic             w_in;
    logic             w_out;
    logic             w_main_ld;
    logic             w_skid_ld;
    logic [Width-1:0] w_main_d;
    logic [Width-1:0] w_main_q;
    logic [Width-1:0] w_skid_q;

    // r_ready is registered, so acceptance never depends combinationally on
    // ready_i; valid_i offered while r_ready is low is simply ignored.
    assign w_in  = valid_i & r_ready;
    assign w_out = valid_o & ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_skid_ld   = 1'b0;
        w_main_d    = data_i;
        case (r_state)
            EMPTY: begin
                if (w_in) begin
                    w_main_ld   = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_in && w_out) begin
                    w_main_ld = 1'b1;               // streaming
                end else if (w_in) begin
                    w_skid_ld   = 1'b1;             // consumer stalled: park beat
                    w_state_nxt = FULL;
                end else if (w_out) begin
                    w_state_nxt = EMPTY;            // main keeps stale value
                end
            end
            FULL: begin
                // No input can arrive here because r_ready is low.
                if (w_out) begin
                    w_main_ld   = 1'b1;
                    w_main_d    = w_skid_q;
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;                // unreachable encoding
            end
        endcase
    end

    // ready is low during reset and rises at the first edge afterwards, since
    // the next state out of reset is EMPTY.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != FULL);
        end
    end

    data_reg_en #(.Width(Width)) u_main (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .en_i     (w_main_ld),
        .d_i      (w_main_d),
        .q_o      (w_main_q)
    );

    data_reg_en #(.Width(Width)) u_skid (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .en_i     (w_skid_ld),
        .d_i      (data_i),
        .q_o      (w_skid_q)
    );

    assign ready_o     = r_ready;
    assign valid_o     = (r_state != EMPTY);
    assign data_o      = w_main_q;
    // State encoding equals the entry count.
    assign occupancy_o = r_state;

endmodule : elastic_skid_buffer

// File: tb/tb_elastic_skid_buffer.sv
module tb_elastic_skid_buffer;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;
    logic [1:0] occupancy_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] sb[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    elastic_skid_buffer #(.Width(8)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs are driven 1 time unit after the rising edge; the scoreboard
    // samples on the falling edge when inputs and outputs are settled.
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_chk++;
                if (valid_o !== 1'b1 || data_o !== prev_data)
                    $display("FAIL stall_hold: valid_o=%0b data_o=%02h want valid_o=1 data_o=%02h",
                             valid_o, data_o, prev_data);
                else n_pass++;
            end
            if (valid_o && ready_i) begin
                n_chk++;
                if (sb.size() == 0)
                    $display("FAIL sb_underflow: data_o=%02h emitted, none expected", data_o);
                else begin
                    logic [7:0] exp;
                    exp = sb.pop_front();
                    if (data_o !== exp)
                        $display("FAIL sb_data: got %02h want %02h", data_o, exp);
                    else n_pass++;
                end
            end
            if (valid_i && ready_o) sb.push_back(data_i);
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; valid_i = 1'b1; data_i = 8'hAA; ready_i = 1'b0;
        #3;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid_o); else n_pass++;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL rst_ready: got %0b want 0", ready_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy_o); else n_pass++;
        step(); step();
        n_chk++; if (data_o !== 8'h00) $display("FAIL rst_data: got %02h want 00", data_o); else n_pass++;
        reset_ni = 1'b1;
        #2;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL rel_ready_early: got %0b want 0", ready_o); else n_pass++;
        step();
        n_chk++; if (ready_o !== 1'b1) $display("FAIL rel_ready: got %0b want 1", ready_o); else n_pass++;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL rel_nocapture: got %0b want 0", valid_o); else n_pass++;
        valid_i = 1'b0;
        step();
        n_chk++; if (occupancy_o !== 2'd0) $display("FAIL rel_occ: got %0d want 0", occupancy_o); else n_pass++;
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1; data_i = 8'(i);
            step();
            n_chk++;
            if (valid_o !== 1'b1 || data_o !== 8'(i) || occupancy_o !== 2'd1)
                $display("FAIL stream_%0d: valid=%0b data=%02h occ=%0d want 1 %02h 1",
                         i, valid_o, data_o, occupancy_o, 8'(i));
            else n_pass++;
        end
        valid_i = 1'b0;
        step();
        n_chk++; if (valid_o !== 1'b0) $display("FAIL stream_end: valid=%0b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_skid_fill();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h11;
        step();
        n_chk++; if (occupancy_o !== 2'd1 || data_o !== 8'h11 || ready_o !== 1'b1)
            $display("FAIL fill1: occ=%0d data=%02h ready=%0b want 1 11 1", occupancy_o, data_o, ready_o);
        else n_pass++;
        data_i = 8'h22;
        step();
        n_chk++; if (occupancy_o !== 2'd2 || data_o !== 8'h11 || ready_o !== 1'b0)
            $display("FAIL fill2: occ=%0d data=%02h ready=%0b want 2 11 0", occupancy_o, data_o, ready_o);
        else n_pass++;
        data_i = 8'h33;
        step();
        n_chk++; if (occupancy_o !== 2'd2 || data_o !== 8'h11 || ready_o !== 1'b0)
            $display("FAIL fill3: occ=%0d data=%02h ready=%0b want 2 11 0", occupancy_o, data_o, ready_o);
        else n_pass++;
        valid_i = 1'b0;
    endtask

    task automatic test_drain();
        ready_i = 1'b1;
        step();
        n_chk++; if (data_o !== 8'h22 || occupancy_o !== 2'd1 || ready_o !== 1'b1)
            $display("FAIL drain1: data=%02h occ=%0d ready=%0b want 22 1 1", data_o, occupancy_o, ready_o);
        else n_pass++;
        step();
        n_chk++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0)
            $display("FAIL drain2: valid=%0b occ=%0d want 0 0", valid_o, occupancy_o);
        else n_pass++;
        n_chk++; if (sb.size() != 0) $display("FAIL drain_sb: %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_random();
        int acc = 0;
        int cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = 8'($urandom);
            if (valid_i && ready_o) acc++;
            step();
            cyc++;
        end
        n_chk++; if (acc != 1000) $display("FAIL rand_timeout: accepted %0d want 1000", acc); else n_pass++;
        valid_i = 1'b0; ready_i = 1'b1;
        cyc = 0;
        while (valid_o && cyc < 10) begin step(); cyc++; end
        n_chk++; if (valid_o !== 1'b0 || sb.size() != 0)
            $display("FAIL rand_drain: valid=%0b sb=%0d want 0 0", valid_o, sb.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 8'hC1;
        step();
        data_i = 8'hC2;
        step();
        valid_i = 1'b0;
        n_chk++; if (occupancy_o !== 2'd2) $display("FAIL mid_full: occ=%0d want 2", occupancy_o); else n_pass++;
        #2 reset_ni = 1'b0;
        #1;
        n_chk++; if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || ready_o !== 1'b0)
            $display("FAIL mid_rst: valid=%0b occ=%0d ready=%0b want 0 0 0", valid_o, occupancy_o, ready_o);
        else n_pass++;
        step();
        reset_ni = 1'b1;
        step();
        valid_i = 1'b1; data_i = 8'h5A; ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        n_chk++; if (valid_o !== 1'b1 || data_o !== 8'h5A)
            $display("FAIL mid_new: valid=%0b data=%02h want 1 5a", valid_o, data_o);
        else n_pass++;
        step();
        n_chk++; if (valid_o !== 1'b0) $display("FAIL mid_empty: valid=%0b want 0", valid_o); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_streaming();
        test_skid_fill();
        test_drain();
        test_random();
        test_mid_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
